// File: rtl/bresenham_raycast.sv
// Grid ray caster: walks (x0,y0)->(x1,y1) with all-octant Bresenham stepping, reading one map cell
// per step and stopping at the first cell whose occupancy reaches OCC_THRESHOLD, or at the endpoint.
module bresenham_raycast #(
   parameter int X_WIDTH       = 8,
   parameter int Y_WIDTH       = 8,
   parameter int CELL_WIDTH    = 8,
   parameter int OCC_THRESHOLD = 128,
   localparam int S_WIDTH      = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [X_WIDTH-1:0]         x0,
   input  logic [Y_WIDTH-1:0]         y0,
   input  logic [X_WIDTH-1:0]         x1,
   input  logic [Y_WIDTH-1:0]         y1,
   output logic                       ram_re,
   output logic [X_WIDTH+Y_WIDTH-1:0] ram_addr,
   input  logic [CELL_WIDTH-1:0]      ram_rdata,
   output logic                       busy,
   output logic                       done,
   output logic                       hit,
   output logic [X_WIDTH-1:0]         hit_x,
   output logic [Y_WIDTH-1:0]         hit_y,
   output logic [S_WIDTH-1:0]         steps
);
   localparam int W = S_WIDTH + 2;
   localparam logic [CELL_WIDTH:0] OCC_LIM = (CELL_WIDTH+1)'(OCC_THRESHOLD);

   typedef enum logic [2:0] {IDLE, SETUP, ISSUE, CHECK, DONE} state_t;

   state_t                       state_q, state_d;
   logic [X_WIDTH-1:0]           x0_q, x0_d, x1_q, x1_d, x_q, x_d, hit_x_q, hit_x_d;
   logic [Y_WIDTH-1:0]           y0_q, y0_d, y1_q, y1_d, y_q, y_d, hit_y_q, hit_y_d;
   logic signed [W-1:0]          dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                         sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
   logic [S_WIDTH-1:0]           cnt_q, cnt_d, steps_q, steps_d;
   logic                         busy_q, busy_d, done_q, done_d, hit_q, hit_d;
   logic                         ram_re_q, ram_re_d;
   logic [X_WIDTH+Y_WIDTH-1:0]   ram_addr_q, ram_addr_d;

   logic [W-1:0]                 adx, ady;
   logic signed [W:0]            e2, dx_ext, dy_ext;
   logic signed [W-1:0]          err_n;

   always_comb begin
      state_d    = state_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      x1_d       = x1_q;
      y1_d       = y1_q;
      x_d        = x_q;
      y_d        = y_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      err_d      = err_q;
      sx_neg_d   = sx_neg_q;
      sy_neg_d   = sy_neg_q;
      cnt_d      = cnt_q;
      hit_d      = hit_q;
      hit_x_d    = hit_x_q;
      hit_y_d    = hit_y_q;
      steps_d    = steps_q;
      ram_addr_d = ram_addr_q;
      adx        = (x1_q >= x0_q) ? W'(x1_q - x0_q) : W'(x0_q - x1_q);
      ady        = (y1_q >= y0_q) ? W'(y1_q - y0_q) : W'(y0_q - y1_q);
      // 2*err needs one bit more than err; dx/dy are sign-extended to match
      e2         = {err_q, 1'b0};
      dx_ext     = {dx_q[W-1], dx_q};
      dy_ext     = {dy_q[W-1], dy_q};
      err_n      = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               x0_d    = x0;
               y0_d    = y0;
               x1_d    = x1;
               y1_d    = y1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            dx_d     = $signed(adx);
            dy_d     = -$signed(ady);
            err_d    = $signed(adx) - $signed(ady);
            sx_neg_d = (x1_q < x0_q);
            sy_neg_d = (y1_q < y0_q);
            x_d      = x0_q;
            y_d      = y0_q;
            cnt_d    = '0;
            hit_d    = 1'b0;
            state_d  = ISSUE;
         end
         ISSUE: state_d = CHECK;
         CHECK: begin
            if ({1'b0, ram_rdata} >= OCC_LIM) begin
               hit_d   = 1'b1;
               hit_x_d = x_q;
               hit_y_d = y_q;
               steps_d = cnt_q;
               state_d = DONE;
            end else if (x_q == x1_q && y_q == y1_q) begin
               hit_d   = 1'b0;
               hit_x_d = x1_q;
               hit_y_d = y1_q;
               steps_d = cnt_q;
               state_d = DONE;
            end else begin
               // both updates may fire in the same step, giving a diagonal move
               if (e2 >= dy_ext) begin
                  err_n = err_n + dy_q;
                  x_d   = sx_neg_q ? x_q - X_WIDTH'(1) : x_q + X_WIDTH'(1);
               end
               if (e2 <= dx_ext) begin
                  err_n = err_n + dx_q;
                  y_d   = sy_neg_q ? y_q - Y_WIDTH'(1) : y_q + Y_WIDTH'(1);
               end
               err_d   = err_n;
               cnt_d   = cnt_q + S_WIDTH'(1);
               state_d = ISSUE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      ram_re_d = (state_d == ISSUE);
      if (state_d == ISSUE) ram_addr_d = {y_d, x_d};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         x0_q       <= '0;
         y0_q       <= '0;
         x1_q       <= '0;
         y1_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         err_q      <= '0;
         sx_neg_q   <= 1'b0;
         sy_neg_q   <= 1'b0;
         cnt_q      <= '0;
         hit_q      <= 1'b0;
         hit_x_q    <= '0;
         hit_y_q    <= '0;
         steps_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ram_re_q   <= 1'b0;
         ram_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         x1_q       <= x1_d;
         y1_q       <= y1_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         err_q      <= err_d;
         sx_neg_q   <= sx_neg_d;
         sy_neg_q   <= sy_neg_d;
         cnt_q      <= cnt_d;
         hit_q      <= hit_d;
         hit_x_q    <= hit_x_d;
         hit_y_q    <= hit_y_d;
         steps_q    <= steps_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ram_re_q   <= ram_re_d;
         ram_addr_q <= ram_addr_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hit      = hit_q;
   assign hit_x    = hit_x_q;
   assign hit_y    = hit_y_q;
   assign steps    = steps_q;
   assign ram_re   = ram_re_q;
   assign ram_addr = ram_addr_q;
endmodule

// File: tb/tb_bresenham_raycast.sv
// Directed bench for bresenham_raycast: a vector table of rays with hand-computed results, plus
// sequences for path order, start held high, and reset in the middle of a ray.
module tb_bresenham_raycast;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic        ram_re;
   logic [15:0] ram_addr;
   logic [7:0]  ram_rdata = '0;
   logic        busy, done, hit;
   logic [7:0]  hit_x, hit_y, steps;

   logic [7:0]  mem [0:65535];
   logic [15:0] reads [$];
   int          checks = 0;
   int          errors = 0;

   bresenham_raycast dut (
      .clock(clock), .reset(reset), .start(start),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
      .busy(busy), .done(done), .hit(hit),
      .hit_x(hit_x), .hit_y(hit_y), .steps(steps)
   );

   always #5 clock = ~clock;

   // map RAM with one-cycle registered read; also logs every read address
   always @(posedge clock) begin
      if (ram_re) begin
         ram_rdata <= mem[ram_addr];
         reads.push_back(ram_addr);
      end
   end

   typedef struct {
      int x0, y0, x1, y1;
      int ox, oy, oval;
      int ehit, ehx, ehy, esteps, elat, nrd;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // start a ray, return edges from start sample to done (200 = timeout)
   task automatic run_ray(input int ax0, input int ay0, input int ax1, input int ay1,
                          output int lat);
      int n;
      @(posedge clock); #1;
      x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1);
      start = 1'b1;
      reads.delete();
      @(posedge clock); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      lat = n;
   endtask

   initial begin
      int lat;
      int dedge [$];
      logic [15:0] path [5];

      for (int i = 0; i < 65536; i++) mem[i] = 8'd0;

      //          x0  y0  x1  y1  ox  oy  oval  hit hx  hy st lat nrd
      vecs[0] = '{0,   0,  7,  0,  0,  0,   0,  0,  7,  0, 7, 17, 8};
      vecs[1] = '{0,   0,  7,  0,  5,  0, 200,  1,  5,  0, 5, 13, 6};
      vecs[2] = '{10, 10,  6, 13,  0,  0,   0,  0,  6, 13, 4, 11, 5};
      vecs[3] = '{3,   3,  3,  3,  3,  3, 127,  0,  3,  3, 0,  3, 1};
      vecs[4] = '{3,   3,  3,  3,  3,  3, 128,  1,  3,  3, 0,  3, 1};
      vecs[5] = '{2,  20,  2, 15,  0,  0,   0,  0,  2, 15, 5, 13, 6};
      vecs[6] = '{0,   0,  4,  4,  3,  3, 255,  1,  3,  3, 3,  9, 4};
      vecs[7] = '{255,255,250,250, 0,  0,   0,  0,250,250, 5, 13, 6};

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done_re_hit", int'({done, ram_re, hit}), 0);
      chk("reset_addr", int'(ram_addr), 0);
      chk("reset_result", int'({hit_x, hit_y, steps}), 0);

      for (int v = 0; v < 8; v++) begin
         mem[vecs[v].oy*256 + vecs[v].ox] = 8'(vecs[v].oval);
         run_ray(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, lat);
         $display("ray %0d (%0d,%0d)->(%0d,%0d): hit=%0d at (%0d,%0d) steps=%0d latency=%0d reads=%0d",
                  v, vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1,
                  hit, hit_x, hit_y, steps, lat, reads.size());
         chk($sformatf("v%0d_latency", v), lat, vecs[v].elat);
         chk($sformatf("v%0d_hit", v), int'(hit), vecs[v].ehit);
         chk($sformatf("v%0d_hit_x", v), int'(hit_x), vecs[v].ehx);
         chk($sformatf("v%0d_hit_y", v), int'(hit_y), vecs[v].ehy);
         chk($sformatf("v%0d_steps", v), int'(steps), vecs[v].esteps);
         chk($sformatf("v%0d_nreads", v), reads.size(), vecs[v].nrd);
         if (reads.size() > 0)
            chk($sformatf("v%0d_last_addr", v), int'(reads[reads.size()-1]),
                vecs[v].ehy*256 + vecs[v].ehx);
         @(posedge clock); #1;
         chk($sformatf("v%0d_done_one_cycle", v), int'({done, busy}), 0);
         mem[vecs[v].oy*256 + vecs[v].ox] = 8'd0;
      end

      // visiting order of a shallow negative-x ray
      path = '{16'h0A0A, 16'h0B09, 16'h0C08, 16'h0C07, 16'h0D06};
      run_ray(10, 10, 6, 13, lat);
      $display("path ray (10,10)->(6,13): %0d reads", reads.size());
      for (int i = 0; i < 5; i++)
         chk($sformatf("path_addr%0d", i), (i < reads.size()) ? int'(reads[i]) : -1, int'(path[i]));

      // start held high: second ray only after DONE->IDLE, no reads while busy
      @(posedge clock); #1;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd3; y1 = 8'd0;
      start = 1'b1;
      reads.delete();
      @(posedge clock); #1;
      for (int k = 1; k <= 21; k++) begin
         @(posedge clock); #1;
         if (done) dedge.push_back(k);
         if (k == 10) chk("held_reads_first_ray", reads.size(), 4);
         if (k == 20) start = 1'b0;
      end
      $display("held start: done at edges %p, reads=%0d", dedge, reads.size());
      chk("held_done_count", dedge.size(), 2);
      chk("held_done_edge1", (dedge.size() > 0) ? dedge[0] : -1, 9);
      chk("held_done_edge2", (dedge.size() > 1) ? dedge[1] : -1, 20);
      chk("held_total_reads", reads.size(), 8);
      repeat (3) @(posedge clock); #1;
      chk("held_idle_after", int'(busy), 0);

      // leave a nonzero result, then reset during CHECK of step 3
      mem[3*256 + 3] = 8'd200;
      run_ray(3, 3, 3, 3, lat);
      mem[3*256 + 3] = 8'd0;
      @(posedge clock); #1;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd7; y1 = 8'd0;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (8) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      $display("reset mid-ray: busy=%0d ram_re=%0d done=%0d hit=%0d", busy, ram_re, done, hit);
      chk("midreset_busy_re_done", int'({busy, ram_re, done}), 0);
      chk("midreset_result", int'({hit, hit_x, hit_y, steps}), 0);
      chk("midreset_addr", int'(ram_addr), 0);
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         if (done || busy || ram_re) lat++;
      end
      chk("midreset_stays_idle", lat, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
